// File: rtl/pc_fetch_if.sv
// Program counter and next-PC selection for the IF stage.
// Holds a redirect that arrives during a stall and applies it once the stall releases.
module pc_fetch_if #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        halt,
    input  logic        jump,
    input  logic [31:0] jump_dir,
    input  logic        branch_taken,
    input  logic [31:0] branch_dir,
    input  logic        jr,
    input  logic [31:0] jr_dir,
    output logic [31:0] pc,
    output logic [31:0] pc_plus_4,
    output logic [3:0]  pc_upper,
    output logic        flush_if,
    output logic        redirect_pending,
    output logic        misaligned,
    output logic [31:0] fetch_count
);

    // state  | meaning
    // RUN    | normal fetch, sequential or immediate redirect
    // HOLD   | redirect latched during a stall, waiting for release
    // HALTED | pc and fetch_count frozen until reset
    typedef enum logic [1:0] {
        RUN    = 2'd0,
        HOLD   = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] tgt_q, tgt_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] pc_inc;
    logic        req;
    logic [31:0] sel_tgt;
    logic [31:0] apply_tgt;
    logic        do_apply;
    logic        do_seq;

    assign pc_inc  = pc_q + 32'd4;
    assign req     = jr | branch_taken | jump;
    assign sel_tgt = jr ? jr_dir : (branch_taken ? branch_dir : jump_dir);

    always_comb begin
        state_d    = state_q;
        tgt_d      = tgt_q;
        do_apply   = 1'b0;
        do_seq     = 1'b0;
        apply_tgt  = sel_tgt;
        case (state_q)
            RUN: begin
                if (halt) begin
                    state_d = HALTED;
                end else if (!stall) begin
                    if (req) begin
                        do_apply = 1'b1;
                    end else begin
                        do_seq = 1'b1;
                    end
                end else if (req) begin
                    tgt_d   = sel_tgt;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (halt) begin
                    // the pending redirect is dropped on halt
                    tgt_d   = 32'h0;
                    state_d = HALTED;
                end else if (stall) begin
                    if (req) begin
                        tgt_d = sel_tgt;
                    end
                end else begin
                    do_apply  = 1'b1;
                    apply_tgt = req ? sel_tgt : tgt_q;
                    state_d   = RUN;
                end
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_comb begin
        pc_d       = pc_q;
        cnt_d      = cnt_q;
        flush_if   = 1'b0;
        misaligned = 1'b0;
        if (do_apply) begin
            pc_d       = {apply_tgt[31:2], 2'b00};
            cnt_d      = cnt_q + 32'd1;
            flush_if   = 1'b1;
            misaligned = |apply_tgt[1:0];
        end else if (do_seq) begin
            pc_d  = pc_inc;
            cnt_d = cnt_q + 32'd1;
        end
        if (reset) begin
            flush_if   = 1'b0;
            misaligned = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            tgt_q   <= 32'h0;
            cnt_q   <= 32'h0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            tgt_q   <= tgt_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pc               = pc_q;
    assign pc_plus_4        = pc_inc;
    assign pc_upper         = pc_inc[31:28];
    assign redirect_pending = (state_q == HOLD);
    assign fetch_count      = cnt_q;

endmodule
